// File: rtl/log_histogram.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | log_histogram                                                         |
// | Eight saturating bin counters fed by 3-bit log2 results, with total,  |
// | running mode bin, sticky saturation flag and a registered readout.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module log_histogram #(
  parameter int CNT_W = 8,
  parameter int TOT_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [2:0]       in_result,
  input  logic             clear,
  input  logic             rd_en,
  input  logic [2:0]       rd_bin,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic [TOT_W-1:0] total,
  output logic [2:0]       peak_bin,
  output logic             sat_any
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [TOT_W-1:0] c_tot_max = '1;

  logic [CNT_W-1:0] bin_q [8];
  logic [CNT_W-1:0] bin_d [8];
  logic [TOT_W-1:0] total_q, total_d;
  logic [2:0]       peak_q, peak_d;
  logic             sat_q, sat_d;
  logic             rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;

  logic [CNT_W-1:0] bin_inc;
  logic [TOT_W-1:0] total_inc;

  always_comb begin
    bin_d      = bin_q;
    total_d    = total_q;
    peak_d     = peak_q;
    sat_d      = sat_q;
    rd_valid_d = rd_en;
    // Reads see pre-edge contents, so a same-cycle sample or clear is invisible.
    rd_data_d  = rd_en ? bin_q[rd_bin] : rd_data_q;

    bin_inc   = (bin_q[in_result] == c_cnt_max) ? c_cnt_max : bin_q[in_result] + 1'b1;
    total_inc = (total_q == c_tot_max) ? c_tot_max : total_q + 1'b1;

    if (clear) begin
      for (int i = 0; i < 8; i++) bin_d[i] = '0;
      total_d = '0;
      peak_d  = '0;
      sat_d   = 1'b0;
    end else if (in_valid) begin
      bin_d[in_result] = bin_inc;
      total_d          = total_inc;
      if (bin_inc == c_cnt_max || total_inc == c_tot_max) sat_d = 1'b1;
      // Strictly greater: ties, including a pinned saturated bin, keep the peak.
      if (in_result != peak_q && bin_inc > bin_q[peak_q]) peak_d = in_result;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) bin_q[i] <= '0;
      total_q    <= '0;
      peak_q     <= '0;
      sat_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      for (int i = 0; i < 8; i++) bin_q[i] <= bin_d[i];
      total_q    <= total_d;
      peak_q     <= peak_d;
      sat_q      <= sat_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign total    = total_q;
  assign peak_bin = peak_q;
  assign sat_any  = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_log_histogram.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_log_histogram                                                      |
// | Self-checking bench: reference model with read scoreboard plus        |
// | directed checks; a second CNT_W=4 instance covers bin saturation.     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_log_histogram;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, clear = 1'b0, rd_en = 1'b0;
  logic [2:0]  in_result = '0, rd_bin = '0;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic [11:0] total;
  logic [2:0]  peak_bin;
  logic        sat_any;

  logic        in_valid4 = 1'b0, clear4 = 1'b0, rd_en4 = 1'b0;
  logic [2:0]  in_result4 = '0, rd_bin4 = '0;
  logic        rd_valid4;
  logic [3:0]  rd_data4;
  logic [11:0] total4;
  logic [2:0]  peak_bin4;
  logic        sat_any4;

  int n_checks = 0;
  int n_errors = 0;

  int exp_q[$];
  int m_bin[8];
  int m_peak;

  always #5 clk = ~clk;

  log_histogram #(.CNT_W(8), .TOT_W(12)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_result(in_result),
    .clear(clear), .rd_en(rd_en), .rd_bin(rd_bin), .rd_valid(rd_valid),
    .rd_data(rd_data), .total(total), .peak_bin(peak_bin), .sat_any(sat_any)
  );

  log_histogram #(.CNT_W(4), .TOT_W(12)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_result(in_result4),
    .clear(clear4), .rd_en(rd_en4), .rd_bin(rd_bin4), .rd_valid(rd_valid4),
    .rd_data(rd_data4), .total(total4), .peak_bin(peak_bin4), .sat_any(sat_any4)
  );

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [2:0] log2f(input int n);
    logic [2:0] r = 3'd0;
    for (int k = 1; k < 8; k++) if (n >= (1 << k)) r = 3'(k);
    return r;
  endfunction

  // Reference model for the 8-bit instance; queues expected read data.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) m_bin[i] = 0;
      m_peak = 0;
      exp_q.delete();
    end else begin
      if (rd_en) exp_q.push_back(m_bin[rd_bin]);
      if (clear) begin
        for (int i = 0; i < 8; i++) m_bin[i] = 0;
        m_peak = 0;
      end else if (in_valid) begin
        int nv;
        nv = (m_bin[in_result] == 255) ? 255 : m_bin[in_result] + 1;
        if (int'(in_result) != m_peak && nv > m_bin[m_peak]) m_peak = in_result;
        m_bin[in_result] = nv;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (rd_valid) begin
        if (exp_q.size() == 0) check("rd_valid_spurious", 1, 0);
        else check("sb_rd_data", rd_data, exp_q.pop_front());
      end else if (exp_q.size() != 0) begin
        check("rd_valid_missing", 0, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [2:0] b);
    in_valid = 1'b1; in_result = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic read_bin(input logic [2:0] b, input int exp, input string tag);
    rd_en = 1'b1; rd_bin = b;
    step();
    rd_en = 1'b0;
    check({tag, "_valid"}, rd_valid, 1);
    check(tag, rd_data, exp);
  endtask

  initial begin
    int exp_ramp[8];
    exp_ramp = '{2, 2, 4, 8, 16, 32, 64, 128};

    #12 reset = 1'b0;
    step();
    check("rst_total", total, 0);
    check("rst_peak", peak_bin, 0);
    check("rst_sat", sat_any, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    for (int b = 0; b < 8; b++) read_bin(3'(b), 0, "rst_bin");
    step();
    check("rd_pulse_ends", rd_valid, 0);

    // Ramp 0..255 through the log2 mapping.
    for (int n = 0; n < 256; n++) begin
      in_valid = 1'b1; in_result = log2f(n);
      step();
    end
    in_valid = 1'b0;
    check("ramp_total", total, 256);
    check("ramp_peak", peak_bin, 7);
    check("ramp_sat", sat_any, 0);
    for (int b = 0; b < 8; b++) read_bin(3'(b), exp_ramp[b], "ramp_bin");

    // Tie rule.
    clear = 1'b1; step(); clear = 1'b0;
    check("clr_total", total, 0);
    sample(3); sample(5); sample(5); sample(3);
    check("tie_peak", peak_bin, 5);
    read_bin(3, 2, "tie_bin3");
    read_bin(5, 2, "tie_bin5");
    sample(3);
    check("tie_overtake_peak", peak_bin, 3);
    check("tie_total", total, 5);

    // Read/write collision on bin 4.
    clear = 1'b1; step(); clear = 1'b0;
    for (int i = 0; i < 6; i++) sample(4);
    in_valid = 1'b1; in_result = 4; rd_en = 1'b1; rd_bin = 4;
    step();
    in_valid = 1'b0; rd_en = 1'b0;
    check("coll_old", rd_data, 6);
    read_bin(4, 7, "coll_new");

    // Clear wins over a same-cycle sample; same-cycle read sees old data.
    clear = 1'b1; in_valid = 1'b1; in_result = 1; rd_en = 1'b1; rd_bin = 4;
    step();
    clear = 1'b0; in_valid = 1'b0; rd_en = 1'b0;
    check("clr_rd_preclear", rd_data, 7);
    check("clr_prio_total", total, 0);
    check("clr_prio_peak", peak_bin, 0);
    read_bin(1, 0, "clr_prio_bin1");
    read_bin(4, 0, "clr_prio_bin4");

    // Asynchronous reset between samples with a read in flight.
    sample(6);
    in_valid = 1'b1; in_result = 6; rd_en = 1'b1; rd_bin = 6;
    @(posedge clk);
    in_valid = 1'b0; rd_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_total", total, 0);
    check("arst_peak", peak_bin, 0);
    check("arst_rd_valid", rd_valid, 0);
    check("arst_rd_data", rd_data, 0);
    step();
    reset = 1'b0;
    step();
    read_bin(6, 0, "arst_bin6");

    // Saturation on the CNT_W=4 instance.
    for (int i = 1; i <= 20; i++) begin
      in_valid4 = 1'b1; in_result4 = 2;
      step();
      if (i == 14) check("sat4_before", sat_any4, 0);
      if (i == 15) check("sat4_at15", sat_any4, 1);
    end
    in_valid4 = 1'b0;
    check("sat4_total", total4, 20);
    check("sat4_sticky", sat_any4, 1);
    check("sat4_peak", peak_bin4, 2);
    rd_en4 = 1'b1; rd_bin4 = 2;
    step();
    rd_en4 = 1'b0;
    check("sat4_rd_valid", rd_valid4, 1);
    check("sat4_bin2", rd_data4, 15);

    step();
    step();
    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
